// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit buffer slice:
//   BYTE_W     - width of one UART character
//   tx_state_e - states of the drain FSM that feeds uart_tx
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_RDY
    } tx_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// -----------------------------------------------------------------------------
// uart_byte_fifo
// Byte FIFO with registered fill status and push/pop arbitration.
//
// Build option: UART_BUF_DROP_OLDEST_EN
//   defined   - push while full (no pop) evicts the oldest entry, keeps the new
//   undefined - push while full (no pop) discards the new byte
//
// Ports:
//   clk    in   clock
//   rst    in   asynchronous reset, active-low (flushes pointers and count)
//   push   in   store wdata this cycle
//   wdata  in   byte to store
//   pop    in   remove the head entry this cycle (ignored when empty)
//   head   out  byte that is at the head after this cycle's eviction, if any
//   count  out  registered number of stored bytes
//   full   out  registered count == DEPTH
//   empty  out  registered count == 0
//   drop   out  a byte is lost this cycle (push while full without pop)
// -----------------------------------------------------------------------------
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [BYTE_W-1:0]       wdata,
    input  logic                    pop,
    output logic [BYTE_W-1:0]       head,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
    output logic                    drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_ptr_inc;
    logic [PTR_W:0]    count_nxt;
    logic              do_pop;
    logic              do_write;
    logic              evict;

    always_comb begin
        do_pop     = pop && !empty;
        drop       = push && full && !do_pop;
        rd_ptr_inc = rd_ptr + PTR_W'(1);
`ifdef UART_BUF_DROP_OLDEST_EN
        // When full, wr_ptr == rd_ptr: the new byte lands on the oldest slot
        // and the read pointer steps past it.
        evict    = drop;
        do_write = push;
`else
        evict    = 1'b0;
        do_write = push && (!full || do_pop);
`endif
        // The drain FSM captures the head on the same edge an eviction may
        // happen, so present the head that survives that edge.
        head = evict ? mem[rd_ptr_inc] : mem[rd_ptr];

        count_nxt = count;
        if (do_write && !do_pop && !evict) begin
            count_nxt = count + 1'b1;
        end else if (do_pop && !do_write) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop || evict) begin
                rd_ptr <= rd_ptr_inc;
            end
            count <= count_nxt;
            full  <= (count_nxt == FULL_CNT);
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// -----------------------------------------------------------------------------
// uart_tx_buffer
// Queues bytes from uart_rx (single-cycle valid) and drains them into uart_tx
// at the transmitter's pace, reporting fill level and a sticky overflow flag.
//
// Build option: UART_BUF_DROP_OLDEST_EN (see uart_byte_fifo) selects whether a
// push into a full buffer discards the oldest or the newest byte.
//
// Ports:
//   clk           in   clock
//   rst           in   asynchronous reset, active-low
//   in_valid      in   one-cycle strobe, byte on in_data
//   in_data       in   received byte
//   tx_rdy        in   uart_tx idle/ready
//   tx_en         out  one-cycle launch strobe to uart_tx (registered)
//   tx_data       out  byte for uart_tx, valid while tx_en is high (registered)
//   count         out  number of stored bytes
//   full          out  count == DEPTH
//   empty         out  count == 0
//   overflow      out  sticky: a byte was discarded
//   clr_overflow  in   synchronous clear of overflow (a new set wins)
// -----------------------------------------------------------------------------
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [BYTE_W-1:0]       in_data,
    input  logic                    tx_rdy,
    output logic                    tx_en,
    output logic [BYTE_W-1:0]       tx_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
    output logic                    overflow,
    input  logic                    clr_overflow
);

    localparam int TO_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);

    tx_state_e         state;
    tx_state_e         state_nxt;
    logic [TO_W-1:0]   to_cnt;
    logic [TO_W-1:0]   to_cnt_nxt;
    logic [BYTE_W-1:0] head;
    logic              drop;
    logic              pop;

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .wdata (in_data),
        .pop   (pop),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty),
        .drop  (drop)
    );

    // The head leaves the FIFO during the LAUNCH cycle; tx_data already holds it.
    assign pop = (state == LAUNCH);

    always_comb begin
        state_nxt  = state;
        to_cnt_nxt = to_cnt;
        case (state)
            IDLE: begin
                if (!empty && tx_rdy) begin
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                state_nxt  = WAIT_BUSY;
                to_cnt_nxt = '0;
            end
            WAIT_BUSY: begin
                // A transmitter that never drops rdy is assumed to have
                // taken the byte once the timeout expires.
                if (!tx_rdy) begin
                    state_nxt = WAIT_RDY;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end
            WAIT_RDY: begin
                if (tx_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            to_cnt   <= '0;
            tx_en    <= 1'b0;
            tx_data  <= '0;
            overflow <= 1'b0;
        end else begin
            state  <= state_nxt;
            to_cnt <= to_cnt_nxt;
            tx_en  <= (state_nxt == LAUNCH);
            if (state_nxt == LAUNCH) begin
                tx_data <= head;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
module tb_uart_tx_buffer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          tb_rdy;
    logic          model_en;
    logic          model_rdy = 1'b1;
    logic          tx_rdy;
    logic          tx_en;
    logic [7:0]    tx_data;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          clr_overflow;

    int n_checks  = 0;
    int n_fail    = 0;
    int proto_err = 0;
    int busy      = 0;
    logic prev_en = 1'b0;
    logic [7:0] got[$];

    always #5 clk = ~clk;

    assign tx_rdy = model_en ? model_rdy : tb_rdy;

    uart_tx_buffer #(
        .DEPTH        (DEPTH),
        .BUSY_TIMEOUT (7)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .tx_rdy       (tx_rdy),
        .tx_en        (tx_en),
        .tx_data      (tx_data),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    // Launch monitor plus uart_tx model: rdy drops for 20 cycles after each en.
    always @(negedge clk) begin
        if (tx_en === 1'b1) begin
            got.push_back(tx_data);
            if (prev_en || tx_rdy !== 1'b1) proto_err++;
        end
        prev_en = (tx_en === 1'b1);
        if (tx_en === 1'b1) busy = 20;
        else if (busy > 0) busy--;
        model_rdy = (busy == 0);
    end

    typedef struct {
        logic          v;
        logic [7:0]    d;
        logic          clr;
        logic [CW-1:0] cnt;
        logic          fu;
        logic          em;
        logic          ov;
        logic          en;
    } vec_t;

    vec_t       tbl[8];
    logic [7:0] exp_ovf[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bytes(input int target, input string name);
        for (int t = 0; t < 600 && got.size() < target; t++) tick();
        chk(name, 32'(got.size() >= target), 1);
    endtask

    initial begin
        int base;

        // count after, full, empty, overflow, tx_en; tx_rdy held low
        tbl[0] = '{1'b1, 8'h10, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 8'h11, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 8'h12, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 8'h13, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 8'h14, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 8'h15, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef UART_BUF_DROP_OLDEST_EN
        exp_ovf = '{8'h12, 8'h13, 8'h14, 8'h15};
`else
        exp_ovf = '{8'h10, 8'h11, 8'h12, 8'h13};
`endif

        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; clr_overflow = 1'b0;
        tb_rdy = 1'b0; model_en = 1'b0;
        repeat (3) tick();
        chk("rst_tx_en", 32'(tx_en), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_overflow", 32'(overflow), 0);
        rst = 1'b1;
        tick();

        // Fill past full with the transmitter stalled.
        for (int i = 0; i < 8; i++) begin
            in_valid = tbl[i].v; in_data = tbl[i].d; clr_overflow = tbl[i].clr;
            tick();
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_full", i), 32'(full), 32'(tbl[i].fu));
            chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].em));
            chk($sformatf("tbl%0d_overflow", i), 32'(overflow), 32'(tbl[i].ov));
            chk($sformatf("tbl%0d_tx_en", i), 32'(tx_en), 32'(tbl[i].en));
        end
        in_valid = 1'b0; clr_overflow = 1'b0;

        base = got.size();
        model_en = 1'b1;
        wait_bytes(base + 4, "ovf_drain_timeout");
        for (int k = 0; k < 4; k++)
            if (got.size() > base + k) chk($sformatf("ovf_byte%0d", k), 32'(got[base+k]), 32'(exp_ovf[k]));
        repeat (2) tick();
        chk("ovf_drained_empty", 32'(empty), 1);
        chk("ovf_sticky", 32'(overflow), 1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("ovf_cleared", 32'(overflow), 0);

        // Single byte latency: in_valid in cycle N -> tx_en in N+2.
        model_en = 1'b0; tb_rdy = 1'b1;
        repeat (30) tick();
        base = got.size();
        in_valid = 1'b1; in_data = 8'h41;
        tick();
        in_valid = 1'b0;
        chk("single_count_n1", 32'(count), 1);
        chk("single_en_n1", 32'(tx_en), 0);
        tick();
        chk("single_en_n2", 32'(tx_en), 1);
        chk("single_data_n2", 32'(tx_data), 32'h41);
        chk("single_count_n2", 32'(count), 1);
        tick();
        chk("single_en_n3", 32'(tx_en), 0);
        chk("single_count_n3", 32'(count), 0);
        chk("single_launches", 32'(got.size()), 32'(base + 1));

        // Burst of five against the modelled transmitter.
        repeat (30) tick();
        model_en = 1'b1;
        repeat (25) tick();
        base = got.size();
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_data = 8'(k + 1);
            tick();
        end
        in_valid = 1'b0;
        wait_bytes(base + 5, "burst_timeout");
        for (int k = 0; k < 5; k++)
            if (got.size() > base + k) chk($sformatf("burst_byte%0d", k), 32'(got[base+k]), 32'(k + 1));
        chk("burst_overflow", 32'(overflow), 0);

        // Push in the LAUNCH cycle while full.
        repeat (30) tick();
        model_en = 1'b0; tb_rdy = 1'b0;
        repeat (2) tick();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = 8'h30 + 8'(k);
            tick();
        end
        in_valid = 1'b0;
        chk("pp_full_before", 32'(full), 1);
        base = got.size();
        tb_rdy = 1'b1;
        tick();
        chk("pp_launch_en", 32'(tx_en), 1);
        chk("pp_launch_data", 32'(tx_data), 32'h30);
        in_valid = 1'b1; in_data = 8'h20;
        tick();
        in_valid = 1'b0;
        chk("pp_count", 32'(count), 4);
        chk("pp_full", 32'(full), 1);
        chk("pp_overflow", 32'(overflow), 0);
        model_en = 1'b1;
        wait_bytes(base + 5, "pp_timeout");
        if (got.size() > base + 4) begin
            chk("pp_byte0", 32'(got[base]), 32'h30);
            chk("pp_byte1", 32'(got[base+1]), 32'h31);
            chk("pp_byte3", 32'(got[base+3]), 32'h33);
            chk("pp_byte_last", 32'(got[base+4]), 32'h20);
        end

        // Reset mid-stream: one byte in flight, three queued, FSM in WAIT_RDY.
        repeat (30) tick();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = 8'h50 + 8'(k);
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("mid_count_before", 32'(count), 3);
        base = got.size();
        rst = 1'b0;
        repeat (2) tick();
        chk("mid_empty", 32'(empty), 1);
        chk("mid_count", 32'(count), 0);
        chk("mid_tx_en", 32'(tx_en), 0);
        chk("mid_full", 32'(full), 0);
        rst = 1'b1;
        model_en = 1'b0; tb_rdy = 1'b1;
        repeat (12) tick();
        chk("mid_no_launch", 32'(got.size()), 32'(base));
        chk("mid_still_empty", 32'(empty), 1);

        chk("launch_protocol", 32'(proto_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffer.md
# uart_tx_buffer

Byte buffer between a `uart_rx` output (single-cycle `valid` plus `data_rx`) and a `uart_tx` input (`en`/`rdy`). In the UART man-in-the-middle path, bytes that arrive while the transmitter is busy are currently lost. This block queues them instead. It drains the queue into `uart_tx` at that transmitter's pace and reports fill level and overflow.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, minimum 2.
- `BUSY_TIMEOUT`, 7: maximum cycles to wait for `tx_rdy` to fall after a launch.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous reset, active-low.
- `in_valid`  in  1  one-cycle strobe; byte present on `in_data`.
- `in_data`  in  8  received byte.
- `tx_rdy`  in  1  `uart_tx` idle/ready.
- `tx_en`  out  1  one-cycle launch strobe to `uart_tx`.
- `tx_data`  out  8  byte for `uart_tx`; valid while `tx_en` is high.
- `count`  out  $clog2(DEPTH)+1  current number of stored bytes.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `overflow`  out  1  sticky flag: a byte was discarded.
- `clr_overflow`  in  1  synchronous clear of `overflow`.

## Operation
- **Reset values** (while `rst` is low): `tx_en`=0, `tx_data`=0, `count`=0, `full`=0, `empty`=1, `overflow`=0, FSM in IDLE.
- **Write path:** a byte is pushed on every `in_valid`. Pointers wrap modulo `DEPTH`.
- **Push while full, no pop in the same cycle:** the new byte is discarded and `overflow` is set.
- **Push and pop in the same cycle:** both take effect and `count` is unchanged. This also holds when full, so no overflow occurs.
- **`overflow` priority:** a set in the same cycle as `clr_overflow` wins.
- **Drain FSM:**
  - IDLE: if !`empty` and `tx_rdy`, go to LAUNCH.
  - LAUNCH: `tx_en`=1 for exactly this cycle. `tx_data` holds the head byte, and the head is popped. Go to WAIT_BUSY.
  - WAIT_BUSY: when `tx_rdy`=0, go to WAIT_RDY. If `BUSY_TIMEOUT` cycles pass with `tx_rdy` still high, treat the byte as accepted and go to IDLE.
  - WAIT_RDY: when `tx_rdy`=1, go to IDLE.
- **`tx_en` guarantee:** never high on two consecutive cycles; never high unless `tx_rdy` was high in the preceding cycle.
- **Reset during operation:** the FIFO is flushed and the FSM returns to IDLE. A byte already launched into `uart_tx` completes independently.

## Timing
- `tx_en`, `tx_data`, `count`, `full`, `empty` and `overflow` are all registered.
- **Latency:** with the buffer empty, FSM in IDLE and `tx_rdy` high, `in_valid` in cycle N produces `tx_en` in cycle N+2.
- **Launch spacing:** at least 3 cycles between consecutive launches (LAUNCH, WAIT_BUSY, WAIT_RDY, IDLE).
- **Status update:** `count`, `full` and `empty` update on the edge after the push or pop.

## Configuration
- `UART_BUF_DROP_OLDEST_EN`
  - Defined: a push while full with no simultaneous pop overwrites the oldest entry by advancing the read pointer. The new byte is kept, `count` stays `DEPTH`, and `overflow` is set.
  - Undefined: the newest byte is dropped, as described in Operation.

## Structure
- **Package `uart_pkg`:** FSM state enum (IDLE, LAUNCH, WAIT_BUSY, WAIT_RDY) and the byte width constant (8).
- **Sub-module `uart_byte_fifo`:** storage array, pointers, count, full/empty and push/pop arbitration.
- **Top level:** drain FSM, timeout counter and overflow logic.

## Test plan
- **Single byte:** empty buffer, `tx_rdy`=1; pulse `in_valid` with 0x41 -> `tx_en` for 1 cycle at N+2 with `tx_data`=0x41; `count` goes 1 then 0.
- **Burst:** push 0x01..0x05 on consecutive cycles; model `uart_tx` with `rdy` low for 20 cycles after each `en` -> bytes emitted in order 0x01..0x05; `overflow`=0.
- **Overflow, drop-newest:** `DEPTH`=4, `tx_rdy` held low, push 0x10..0x14 -> `count`=4, `overflow`=1; after `tx_rdy` rises, output is 0x10..0x13.
- **Overflow, drop-oldest:** same stimulus with `UART_BUF_DROP_OLDEST_EN` defined -> output is 0x11..0x14, `overflow`=1.
- **Simultaneous push/pop when full:** `DEPTH`=4, full; push 0x20 in the LAUNCH cycle -> `count` stays 4, `overflow`=0, 0x20 is emitted last.
- **Reset mid-stream:** 3 bytes queued and FSM in WAIT_RDY; assert `rst` low for 2 cycles -> `empty`=1, `count`=0, `tx_en`=0, FSM IDLE; `tx_rdy`=1 afterwards produces no launch.
